// File: rtl/phase_arbiter.sv
// Round-robin phase scheduler for the intersection controller: latches car/ped
// requests, grants one phase at a time and owns all green/walk/yellow/all-red timing.
module phase_arbiter #(
    parameter int WIDTH       = 8,
    parameter int MIN_GREEN   = 5,
    parameter int MAX_GREEN   = 20,
    parameter int WALK_TIME   = 10,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] req,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic       all_red,
    output logic [1:0] active_phase,
    output logic [3:0] pending
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } state_t;

    localparam logic [WIDTH:0]   MIN_T     = (WIDTH+1)'(MIN_GREEN);
    localparam logic [WIDTH:0]   MAX_T     = (WIDTH+1)'(MAX_GREEN);
    localparam logic [WIDTH:0]   WALK_T    = (WIDTH+1)'(WALK_TIME);
    localparam logic [WIDTH:0]   YELLOW_T  = (WIDTH+1)'(YELLOW_TIME);
    localparam logic [WIDTH:0]   ALLRED_T  = (WIDTH+1)'(ALLRED_TIME);
    localparam logic [WIDTH-1:0] TIMER_MAX = '1;

    state_t           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       pending_q, pending_d;
    logic [WIDTH-1:0] timer_q, timer_d;

    logic [1:0]       winner;
    logic             any_pending;
    logic [3:0]       own_bit;
    logic             others_pending;
    logic [WIDTH:0]   elapsed;
    logic             enter_green;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_q     <= 2'd0;
            ptr_q     <= 2'd0;
            pending_q <= 4'd0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
        end
    end

    // Descending scan so the pending bit closest to ptr is the last one written.
    always_comb begin
        winner      = ptr_q;
        any_pending = |pending_q;
        for (int k = 3; k >= 0; k--) begin
            if (pending_q[ptr_q + 2'(k)]) begin
                winner = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        own_bit        = 4'b0001 << cur_q;
        others_pending = |(pending_q & ~own_bit);
        elapsed        = {1'b0, timer_q} + {{WIDTH{1'b0}}, tick};
    end

    // Exits are only taken on tick cycles, so a frozen time base holds every timed state.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        ptr_d       = ptr_q;
        enter_green = 1'b0;
        pending_d   = pending_q | (req & ((state_q == GREEN) ? ~own_bit : 4'b1111));
        timer_d     = (tick && (timer_q != TIMER_MAX)) ? timer_q + WIDTH'(1) : timer_q;

        case (state_q)
            IDLE: begin
                if (any_pending) begin
                    enter_green = 1'b1;
                end
            end
            GREEN: begin
                if (cur_q == 2'd3) begin
                    if (tick && (elapsed >= WALK_T)) begin
                        state_d = YELLOW;
                    end
                end else if (tick && (((elapsed >= MIN_T) && (!req[cur_q] || others_pending))
                                      || (elapsed >= MAX_T))) begin
                    state_d = YELLOW;
                end
            end
            YELLOW: begin
                if (tick && (elapsed >= YELLOW_T)) begin
                    state_d = ALLRED;
                end
            end
            ALLRED: begin
                if (tick && (elapsed >= ALLRED_T)) begin
                    if (any_pending) begin
                        enter_green = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clearing the served bit after the set term makes clear win on the grant edge.
        if (enter_green) begin
            state_d           = GREEN;
            cur_d             = winner;
            ptr_d             = winner + 2'd1;
            pending_d[winner] = 1'b0;
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    assign green        = (state_q == GREEN)  ? own_bit : 4'b0000;
    assign yellow       = (state_q == YELLOW) ? own_bit : 4'b0000;
    assign all_red      = (state_q == IDLE) || (state_q == ALLRED);
    assign active_phase = cur_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_phase_arbiter.sv
// Self-checking bench for phase_arbiter: directed test-plan scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_phase_arbiter;

    localparam int MIN_G  = 2;
    localparam int MAX_G  = 4;
    localparam int WALK   = 3;
    localparam int YEL    = 2;
    localparam int AR     = 1;

    localparam int DARK    = 0;
    localparam int GO      = 1;
    localparam int CAUTION = 2;
    localparam int CLEAR   = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic [3:0] req   = 4'd0;
    logic [3:0] green;
    logic [3:0] yellow;
    logic       all_red;
    logic [1:0] active_phase;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    int         m_mode    = DARK;
    int         m_phase   = 0;
    int         m_next    = 0;
    int         m_elapsed = 0;
    logic [3:0] m_pend    = 4'd0;

    phase_arbiter #(
        .WIDTH(8), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G),
        .WALK_TIME(WALK), .YELLOW_TIME(YEL), .ALLRED_TIME(AR)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .req(req),
        .green(green), .yellow(yellow), .all_red(all_red),
        .active_phase(active_phase), .pending(pending)
    );

    always #5 clock = ~clock;

    function automatic int pick(input logic [3:0] p, input int from);
        for (int k = 0; k < 4; k++) begin
            if (p[(from + k) % 4]) return (from + k) % 4;
        end
        return 0;
    endfunction

    // Behavioural reference: one call per clock edge with the inputs sampled on that edge.
    task automatic modelStep(input logic [3:0] r, input logic t, input logic rs);
        logic [3:0] np;
        logic [3:0] own;
        int         el;
        int         next_mode;
        bit         go_green;
        int         w;
        if (rs) begin
            m_mode = DARK; m_phase = 0; m_next = 0; m_elapsed = 0; m_pend = 4'd0;
            return;
        end
        own       = 4'b0001 << m_phase;
        np        = m_pend | ((m_mode == GO) ? (r & ~own) : r);
        el        = m_elapsed + (t ? 1 : 0);
        next_mode = m_mode;
        go_green  = 1'b0;
        case (m_mode)
            DARK:    go_green = (m_pend != 4'd0);
            GO: begin
                if (m_phase == 3) begin
                    if (t && el >= WALK) next_mode = CAUTION;
                end else if (t && ((el >= MIN_G && (!r[m_phase] || (m_pend & ~own) != 4'd0))
                                   || el >= MAX_G)) begin
                    next_mode = CAUTION;
                end
            end
            CAUTION: if (t && el >= YEL) next_mode = CLEAR;
            default: begin
                if (t && el >= AR) begin
                    if (m_pend != 4'd0) go_green = 1'b1;
                    else next_mode = DARK;
                end
            end
        endcase
        if (go_green) begin
            w         = pick(m_pend, m_next);
            next_mode = GO;
            m_phase   = w;
            np[w]     = 1'b0;
            m_next    = (w + 1) % 4;
        end
        m_elapsed = (go_green || next_mode != m_mode) ? 0 : el;
        m_mode    = next_mode;
        m_pend    = np;
    endtask

    task automatic checkOne(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [3:0] exp_g;
        logic [3:0] exp_y;
        exp_g = (m_mode == GO)      ? (4'b0001 << m_phase) : 4'd0;
        exp_y = (m_mode == CAUTION) ? (4'b0001 << m_phase) : 4'd0;
        checkOne("model_green",   green,  exp_g);
        checkOne("model_yellow",  yellow, exp_y);
        checkOne("model_all_red", {3'd0, all_red}, {3'd0, (m_mode == DARK || m_mode == CLEAR)});
        checkOne("model_active",  {2'd0, active_phase}, 4'(m_phase));
        checkOne("model_pending", pending, m_pend);
        checkOne("onehot", {3'd0, ($countones(green | yellow) <= 1)}, 4'd1);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic t, input logic rs);
        req   = r;
        tick  = t;
        reset = rs;
        @(posedge clock);
        modelStep(r, t, rs);
        #1;
        checkOutput();
    endtask

    task automatic expectLamps(input string tag, input logic [3:0] g, input logic [3:0] y,
                               input logic ar);
        checkOne({tag, "_green"},   green,  g);
        checkOne({tag, "_yellow"},  yellow, y);
        checkOne({tag, "_all_red"}, {3'd0, all_red}, {3'd0, ar});
    endtask

    task automatic runExpect(input logic [3:0] r, input logic t, input int n, input string tag,
                             input logic [3:0] g, input logic [3:0] y, input logic ar);
        for (int i = 0; i < n; i++) begin
            applyStimulus(r, t, 1'b0);
            expectLamps(tag, g, y, ar);
        end
    endtask

    initial begin
        #1;
        // Reset and quiet intersection
        applyStimulus(4'd0, 1'b1, 1'b1);
        applyStimulus(4'd0, 1'b1, 1'b1);
        expectLamps("reset", 4'd0, 4'd0, 1'b1);
        checkOne("reset_pending", pending, 4'd0);
        checkOne("reset_active", {2'd0, active_phase}, 4'd0);
        runExpect(4'd0, 1'b1, 20, "quiet", 4'd0, 4'd0, 1'b1);
        checkOne("quiet_pending", pending, 4'd0);

        // Main road held: MAX_GREEN cycle, then re-served
        applyStimulus(4'd0, 1'b1, 1'b1);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOne("main_latch", pending, 4'b0001);
        runExpect(4'b0001, 1'b1, MAX_G, "main_green", 4'b0001, 4'd0, 1'b0);
        runExpect(4'b0001, 1'b1, YEL, "main_yellow", 4'd0, 4'b0001, 1'b0);
        runExpect(4'b0001, 1'b1, AR, "main_allred", 4'd0, 4'd0, 1'b1);
        runExpect(4'b0001, 1'b1, 1, "main_again", 4'b0001, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(4'd0, 1'b1, 1'b0);
        expectLamps("main_done", 4'd0, 4'd0, 1'b1);

        // Main and side together: round-robin hand-off
        applyStimulus(4'd0, 1'b1, 1'b1);
        applyStimulus(4'b0011, 1'b1, 1'b0);
        checkOne("both_latch", pending, 4'b0011);
        runExpect(4'b0011, 1'b1, MIN_G, "both_green0", 4'b0001, 4'd0, 1'b0);
        runExpect(4'b0011, 1'b1, YEL, "both_yellow0", 4'd0, 4'b0001, 1'b0);
        runExpect(4'b0011, 1'b1, AR, "both_allred", 4'd0, 4'd0, 1'b1);
        runExpect(4'b0011, 1'b1, 1, "both_green1", 4'b0010, 4'd0, 1'b0);
        checkOne("both_active", {2'd0, active_phase}, 4'd1);

        // Pedestrian pulse during side green
        applyStimulus(4'd0, 1'b1, 1'b1);
        applyStimulus(4'b0010, 1'b1, 1'b0);
        runExpect(4'b0000, 1'b1, 1, "ped_side_green", 4'b0010, 4'd0, 1'b0);
        runExpect(4'b1000, 1'b1, 1, "ped_side_green", 4'b0010, 4'd0, 1'b0);
        checkOne("ped_latch", pending, 4'b1000);
        runExpect(4'b0000, 1'b1, YEL, "ped_side_yellow", 4'd0, 4'b0010, 1'b0);
        runExpect(4'b0000, 1'b1, AR, "ped_side_allred", 4'd0, 4'd0, 1'b1);
        runExpect(4'b0000, 1'b1, WALK, "ped_walk", 4'b1000, 4'd0, 1'b0);
        runExpect(4'b0000, 1'b1, YEL, "ped_clear", 4'd0, 4'b1000, 1'b0);
        runExpect(4'b0000, 1'b1, AR + 2, "ped_idle", 4'd0, 4'd0, 1'b1);

        // Frozen time base holds green, then exactly MAX_GREEN ticks
        applyStimulus(4'd0, 1'b1, 1'b1);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        runExpect(4'b0001, 1'b1, 1, "freeze_enter", 4'b0001, 4'd0, 1'b0);
        runExpect(4'b0001, 1'b0, 50, "freeze_hold", 4'b0001, 4'd0, 1'b0);
        runExpect(4'b0001, 1'b1, MAX_G - 1, "freeze_resume", 4'b0001, 4'd0, 1'b0);
        runExpect(4'b0001, 1'b1, 1, "freeze_yellow", 4'd0, 4'b0001, 1'b0);

        // Reset during yellow with side and turn pending
        applyStimulus(4'd0, 1'b1, 1'b1);
        applyStimulus(4'b0111, 1'b1, 1'b0);
        applyStimulus(4'b0110, 1'b1, 1'b0);
        applyStimulus(4'b0110, 1'b1, 1'b0);
        applyStimulus(4'b0110, 1'b1, 1'b0);
        expectLamps("rstyel_pre", 4'd0, 4'b0001, 1'b0);
        checkOne("rstyel_pre_pending", pending, 4'b0110);
        applyStimulus(4'b0110, 1'b1, 1'b1);
        expectLamps("rstyel", 4'd0, 4'd0, 1'b1);
        checkOne("rstyel_pending", pending, 4'd0);
        checkOne("rstyel_active", {2'd0, active_phase}, 4'd0);

        // Randomized traffic against the model
        begin
            logic [3:0] r;
            r = 4'd0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
                applyStimulus(r, ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_arbiter.md
# phase_arbiter

Round-robin phase scheduler for the intersection controller. It latches car and pedestrian requests, then grants exactly one phase at a time: main, side, turn or pedestrian. It owns all phase timing (min/max green, walk, yellow/clearance, all-red) using a shared tick time base. Its one-hot phase outputs drive the lamp-decode logic, which replaces the fixed-priority sequencing with fair, starvation-free service.

## Interface
- WIDTH, 8: width of the tick counter; all time parameters must be in 1..2^WIDTH-1.
- MIN_GREEN, 5: ticks a car phase stays green before it may yield.
- MAX_GREEN, 20: ticks after which a car phase yields unconditionally; must be ≥ MIN_GREEN.
- WALK_TIME, 10: ticks of pedestrian walk (phase 3 green).
- YELLOW_TIME, 3: ticks of yellow for car phases, or flashing clearance for phase 3.
- ALLRED_TIME, 2: ticks of all-red after every yellow.
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clock.
- tick  in  1  single-cycle time-base strobe; timers advance only on cycles with tick=1.
- req  in  4  request levels; [0] main (car1), [1] side (car2), [2] turn (car3|car4), [3] ped button (may be a 1-cycle pulse).
- green  out  4  one-hot green/walk for the active phase.
- yellow  out  4  one-hot yellow/clearance for the active phase.
- all_red  out  1  no phase green or yellow.
- active_phase  out  2  index of the phase being served or last served.
- pending  out  4  latched outstanding requests.

## Operation
- States: IDLE, GREEN, YELLOW, ALLRED. A 2-bit phase register `cur` and a round-robin pointer `ptr` accompany the state.
- Pending latch, updated every cycle:
  - pending[i] sets when req[i]=1.
  - Exception: req[i] is ignored while state=GREEN and cur=i.
  - pending[i] clears on the edge that enters GREEN with cur=i. Clear wins over set on that edge.
- Winner selection: the first i with pending[i]=1, searching ptr, ptr+1, ... modulo 4.
- On entering GREEN for phase w, ptr becomes w+1 mod 4. The just-served phase therefore has lowest priority next time.
- Timer: counts tick pulses since state entry and is zeroed on every state transition. "N ticks elapsed" means the edge sampling the Nth tick=1.
- IDLE:
  - Outputs: all_red=1.
  - If any pending bit is set, go to GREEN with cur = winner on the next edge. Otherwise stay.
- GREEN, car phase (cur=0..2), go to YELLOW when either:
  - MIN_GREEN ticks have elapsed and (req[cur]=0 or any other pending bit is set), or
  - MAX_GREEN ticks have elapsed.
- GREEN, ped phase (cur=3): go to YELLOW after exactly WALK_TIME ticks.
- YELLOW: go to ALLRED after YELLOW_TIME ticks.
- ALLRED: after ALLRED_TIME ticks, go to GREEN with cur = winner if any pending bit is set, else go to IDLE.
- Output decode (Moore, from registered state):
  - green[cur] = 1 in GREEN only.
  - yellow[cur] = 1 in YELLOW only.
  - all_red = 1 in IDLE and ALLRED.
  - At most one bit of green|yellow is ever set.
- A car still present during its own green does not re-pend. A car still present during yellow or all-red re-pends and is served again in round-robin order.

## Timing
- Reset values: state=IDLE, cur=0, ptr=0, pending=0, green=0, yellow=0, all_red=1, active_phase=0.
- Latency:
  - req to pending: 1 cycle.
  - pending to green from IDLE: 1 cycle.
  - Minimum req-to-green from IDLE is therefore 2 cycles.
- Outputs change in the cycle after the edge that changes state.
- Simultaneous requests are resolved by ptr, never by index.
- A tick arriving on the same cycle as a transition counts toward the state being left. The new state's timer starts at 0.
- tick held low freezes all timers. The FSM stays in GREEN, YELLOW or ALLRED indefinitely. IDLE→GREEN does not need tick.
- Reset asserted mid-operation: on the next edge, return to IDLE with all_red=1 and pending cleared. Requests still held re-latch 1 cycle after reset deasserts.
- Timer must not wrap. It saturates at 2^WIDTH-1. Parameters are constrained so the exit condition is always reached first.

## Test plan
All scenarios use MIN_GREEN=2, MAX_GREEN=4, WALK_TIME=3, YELLOW_TIME=2, ALLRED_TIME=1, and tick=1 every cycle unless noted.
- Reset, req=0 for 20 cycles → all_red=1, green=0, yellow=0, pending=0 throughout.
- req=0001 held → pending=0001 at cycle 1 and green=0001 at cycle 2, held 4 cycles (MAX_GREEN). Then yellow=0001 for 2 cycles, all_red for 1 cycle, then green=0001 again.
- req=0011 from reset → phase 0 green for 2 cycles (MIN_GREEN, other pending), yellow 2, all_red 1, then green=0010. ptr=2 afterwards.
- A 1-cycle req[3] pulse during phase 1 green with req[2]=0 → pending[3]=1 stays latched. After phase 1 yellow/all-red, green=1000 for exactly 3 cycles, then yellow=1000 for 2 cycles, then IDLE.
- req=0001 with tick low after entering GREEN → green=0001 stays for 50 cycles. Resuming tick gives exactly MAX_GREEN further ticks.
- Assert reset during YELLOW with pending=0110 → next cycle all_red=1, pending=0000, active_phase=0.
